// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared ALU op, ISA opcode and sequencer state encodings
//
// Purpose: single source of the alu_op encodings, the ISA opcode field values
// and the multi-cycle sequencer state codes, shared by the ALU datapath and
// the sequencer.
// Ports: none (package).

package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_LAND = 4'b0011,
    ALU_LOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_AND  = 4'b0110,
    ALU_OR   = 4'b0111,
    ALU_NOR  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_SRA  = 4'b1100
  } alu_op_e;

  typedef enum logic [3:0] {
    OPC_RTYPE = 4'd0,
    OPC_ADDI  = 4'd1,
    OPC_LW    = 4'd2,
    OPC_SW    = 4'd3,
    OPC_BEQ   = 4'd4,
    OPC_BNE   = 4'd5,
    OPC_J     = 4'd6,
    OPC_HALT  = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU  = 2'b00,
    PC_SRC_BR   = 2'b01,
    PC_SRC_JUMP = 2'b10
  } pc_src_e;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC_R  = 4'd3;
  localparam logic [3:0] S_EXEC_I  = 4'd4;
  localparam logic [3:0] S_WB      = 4'd5;
  localparam logic [3:0] S_MEMADDR = 4'd6;
  localparam logic [3:0] S_MEMACC  = 4'd7;
  localparam logic [3:0] S_WBMEM   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_HALT    = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd12;

  // R-type funct codes the ALU implements; anything else is an illegal instruction.
  function automatic logic funct_valid(input logic [3:0] f);
    return (f >= ALU_ADD) && (f <= ALU_SRA);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - wrapping retired-instruction counter with async clear
//
// Purpose: counts completed instructions, wrapping from all-ones to zero.
// Ports:
//   CLK    - clock, counts on rising edge
//   clear  - asynchronous active-high clear to zero
//   enable - count this cycle
//   count  - current count, W bits

module retire_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle control sequencer for the ALUSystem datapath
//
// Purpose: fetch/decode/execute control FSM driving ALU, PC, IR, memory and
// register-file strobes, with sticky halt/trap status and a retired counter.
// Ports:
//   CLK, reset            - clock, async active-high reset
//   start                 - leaves IDLE (ignored elsewhere)
//   opcode, funct         - IR[15:12] and IR[3:0]
//   isZero, ovfl          - ALU zero and signed-overflow flags
//   mem_ready             - memory completes the current access
//   alu_op, alu_src       - ALU operation and B-operand select
//   ir_write, pc_write    - IR and PC load enables
//   pc_src                - PC source: ALU result, branch target, jump target
//   mem_read, mem_write   - memory strobes
//   reg_write, mem_to_reg - register write enable and write-data select
//   trap, halted          - sticky terminal status
//   retired               - completed-instruction count

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          opcode,
  input  logic [3:0]          funct,
  input  logic                isZero,
  input  logic                ovfl,
  input  logic                mem_ready,
  output logic [3:0]          alu_op,
  output logic                alu_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                trap,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  logic [3:0] state;
  logic [3:0] next_state;

  // Instruction context captured along the way so later states do not depend
  // on the IR field inputs staying valid.
  logic [3:0] wb_op;
  logic       wb_src;
  logic       wb_ovchk;
  logic       is_store;
  logic       branch_ne;

  logic wb_trap;
  logic branch_taken;
  logic retire_en;

  assign wb_trap      = wb_ovchk && ovfl;
  assign branch_taken = branch_ne ? !isZero : isZero;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wb_op     <= '0;
      wb_src    <= 1'b0;
      wb_ovchk  <= 1'b0;
      is_store  <= 1'b0;
      branch_ne <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        is_store  <= (opcode == OPC_SW);
        branch_ne <= (opcode == OPC_BNE);
      end
      if (state == S_EXEC_R) begin
        wb_op    <= funct;
        wb_src   <= 1'b0;
        wb_ovchk <= (funct == ALU_ADD) || (funct == ALU_SUB);
      end
      if (state == S_EXEC_I) begin
        wb_op    <= ALU_ADD;
        wb_src   <= 1'b1;
        wb_ovchk <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_FETCH;
      S_FETCH:   if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_RTYPE:      next_state = S_EXEC_R;
          OPC_ADDI:       next_state = S_EXEC_I;
          OPC_LW, OPC_SW: next_state = S_MEMADDR;
          OPC_BEQ, OPC_BNE: next_state = S_BRANCH;
          OPC_J:          next_state = S_JUMP;
          OPC_HALT:       next_state = S_HALT;
          default:        next_state = S_TRAP;
        endcase
      end
      S_EXEC_R:  next_state = funct_valid(funct) ? S_WB : S_TRAP;
      S_EXEC_I:  next_state = S_WB;
      S_WB:      next_state = wb_trap ? S_TRAP : S_FETCH;
      S_MEMADDR: next_state = S_MEMACC;
      S_MEMACC:  if (mem_ready) next_state = is_store ? S_FETCH : S_WBMEM;
      S_WBMEM:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      S_TRAP:    next_state = S_TRAP;
      // Unused encodings can only come from corruption; park as a trap.
      default:   next_state = S_TRAP;
    endcase
  end

  always_comb begin
    alu_op     = ALU_NONE;
    alu_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    halted     = 1'b0;
    retire_en  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_op   = ALU_ADD;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
      end
      S_EXEC_R: alu_op = funct;
      S_EXEC_I: begin
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
      end
      S_WB: begin
        alu_op    = wb_op;
        alu_src   = wb_src;
        reg_write = !wb_trap;
        retire_en = !wb_trap;
      end
      S_MEMADDR: begin
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
      end
      S_MEMACC: begin
        mem_read  = !is_store;
        mem_write = is_store;
        retire_en = is_store && mem_ready;
      end
      S_WBMEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_en  = 1'b1;
      end
      S_BRANCH: begin
        alu_op    = ALU_SUB;
        pc_write  = branch_taken;
        pc_src    = branch_taken ? PC_SRC_BR : PC_SRC_ALU;
        retire_en = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = PC_SRC_JUMP;
        retire_en = 1'b1;
      end
      S_HALT: halted = 1'b1;
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  retire_counter #(
    .W(RETIRE_W)
  ) u_retire_counter (
    .CLK    (CLK),
    .clear  (reset),
    .enable (retire_en),
    .count  (retired)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer

module tb_alu_sequencer;

  localparam logic [3:0] A_ADD = 4'd1;
  localparam logic [3:0] A_SUB = 4'd2;

  // Observed vector layout: {alu_op, alu_src, ir_write, pc_write, pc_src,
  // mem_read, mem_write, reg_write, mem_to_reg, trap, halted}
  localparam logic [14:0] M_SRC  = 15'h400;
  localparam logic [14:0] M_IRW  = 15'h200;
  localparam logic [14:0] M_PCW  = 15'h100;
  localparam logic [14:0] M_PJ   = 15'h080;
  localparam logic [14:0] M_PBR  = 15'h040;
  localparam logic [14:0] M_MR   = 15'h020;
  localparam logic [14:0] M_MW   = 15'h010;
  localparam logic [14:0] M_RW   = 15'h008;
  localparam logic [14:0] M_M2R  = 15'h004;
  localparam logic [14:0] M_TRAP = 15'h002;
  localparam logic [14:0] M_HALT = 15'h001;

  logic       CLK = 1'b0;
  logic       reset, start, isZero, ovfl, mem_ready;
  logic [3:0] opcode, funct;

  logic [3:0]  alu_op, alu_op4;
  logic        alu_src, alu_src4, ir_write, ir_write4, pc_write, pc_write4;
  logic [1:0]  pc_src, pc_src4;
  logic        mem_read, mem_read4, mem_write, mem_write4;
  logic        reg_write, reg_write4, mem_to_reg, mem_to_reg4;
  logic        trap, trap4, halted, halted4;
  logic [15:0] retired;
  logic [3:0]  retired4;
  logic [14:0] obs, obs4;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] ret_m;

  always #5 CLK = ~CLK;

  assign obs  = {alu_op, alu_src, ir_write, pc_write, pc_src, mem_read, mem_write,
                 reg_write, mem_to_reg, trap, halted};
  assign obs4 = {alu_op4, alu_src4, ir_write4, pc_write4, pc_src4, mem_read4, mem_write4,
                 reg_write4, mem_to_reg4, trap4, halted4};

  alu_sequencer dut (
    .CLK(CLK), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .isZero(isZero), .ovfl(ovfl), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src(alu_src), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .trap(trap), .halted(halted), .retired(retired)
  );

  // Narrow-counter copy so counter wrap is exercised within a short run.
  alu_sequencer #(.RETIRE_W(4)) dut_w4 (
    .CLK(CLK), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .isZero(isZero), .ovfl(ovfl), .mem_ready(mem_ready),
    .alu_op(alu_op4), .alu_src(alu_src4), .ir_write(ir_write4), .pc_write(pc_write4),
    .pc_src(pc_src4), .mem_read(mem_read4), .mem_write(mem_write4), .reg_write(reg_write4),
    .mem_to_reg(mem_to_reg4), .trap(trap4), .halted(halted4), .retired(retired4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] with_op(input logic [3:0] op);
    return {op, 11'b0};
  endfunction

  task automatic check_ret(input string tag);
    check(tag, retired, ret_m);
    check({tag, "_w4"}, retired4, ret_m[3:0]);
  endtask

  // Entered at posedge+1; checks this cycle's outputs, leaves at next posedge+1.
  task automatic step(input string tag, input logic [14:0] exp);
    #3;
    check(tag, obs, exp);
    check({tag, "_w4"}, obs4, exp);
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_start();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1; ovfl = 1'b0; isZero = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_outputs", obs, 15'h0);
    check("rst_retired", retired, 16'h0);
    check("rst_retired_w4", retired4, 4'h0);
    reset = 1'b0;
    ret_m = 16'h0;
    step("idle_wait", 15'h0);
    step("idle_wait2", 15'h0);
    start = 1'b1;
    step("idle_start", 15'h0);
    start = 1'b0;
  endtask

  task automatic check_term(input logic is_trap);
    for (int i = 0; i < 3; i++) begin
      start = 1'(i % 2);
      step(is_trap ? "trap_sticky" : "halt_sticky", is_trap ? M_TRAP : M_HALT);
    end
    check_ret("ret_terminal");
  endtask

  // Reference behaviour of one instruction, starting in its first FETCH cycle.
  // term: 0 retired normally, 1 trapped, 2 halted.
  task automatic do_instr(input logic [3:0] opc, input logic [3:0] fn, input logic iz,
                          input logic ov, input int fstall, input int mstall,
                          output int term);
    logic [3:0]  op;
    logic        src, bad, taken, lw;
    logic [14:0] acc;
    term = 0;
    opcode = opc; funct = fn; isZero = iz; ovfl = ov;
    start = 1'($urandom_range(0, 1));
    check_ret("ret_at_fetch");
    mem_ready = 1'b0;
    for (int i = 0; i < fstall; i++) step("fetch_wait", with_op(A_ADD) | M_MR);
    mem_ready = 1'b1;
    step("fetch", with_op(A_ADD) | M_MR | M_IRW | M_PCW);
    step("decode", with_op(A_ADD) | M_SRC);
    if (opc <= 4'd1) begin
      op  = (opc == 4'd0) ? fn : A_ADD;
      src = (opc == 4'd1);
      step("exec", with_op(op) | (src ? M_SRC : 15'h0));
      if (opc == 4'd0 && (fn == 4'd0 || fn > 4'd12)) begin
        term = 1;
      end else begin
        bad = ov && (opc == 4'd1 || fn == A_ADD || fn == A_SUB);
        step("wb", with_op(op) | (src ? M_SRC : 15'h0) | (bad ? 15'h0 : M_RW));
        if (bad) term = 1;
        else ret_m = ret_m + 16'd1;
      end
    end else if (opc <= 4'd3) begin
      lw = (opc == 4'd2);
      step("memaddr", with_op(A_ADD) | M_SRC);
      acc = lw ? M_MR : M_MW;
      mem_ready = 1'b0;
      for (int i = 0; i < mstall; i++) step("memacc_wait", acc);
      mem_ready = 1'b1;
      step("memacc", acc);
      if (lw) step("wbmem", M_RW | M_M2R);
      ret_m = ret_m + 16'd1;
    end else if (opc <= 4'd5) begin
      taken = (opc == 4'd4) ? iz : !iz;
      step("branch", with_op(A_SUB) | (taken ? (M_PCW | M_PBR) : 15'h0));
      ret_m = ret_m + 16'd1;
    end else if (opc == 4'd6) begin
      step("jump", M_PCW | M_PJ);
      ret_m = ret_m + 16'd1;
    end else if (opc == 4'd7) begin
      term = 2;
    end else begin
      term = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         term;
    int         r;
    logic [3:0] opc, fn;
    logic       iz, ov;

    reset = 1'b1; start = 1'b0; opcode = '0; funct = '0;
    isZero = 1'b0; ovfl = 1'b0; mem_ready = 1'b1; ret_m = '0;

    // R-type add, clean
    reset_start();
    do_instr(4'd0, 4'd1, 1'b0, 1'b0, 0, 0, term);
    check("rtype_term", term, 0);
    check_ret("ret_after_rtype");

    // addi overflowing in WB traps, retired unchanged, start ignored
    do_instr(4'd1, 4'd0, 1'b0, 1'b1, 0, 0, term);
    check("addi_ovfl_term", term, 1);
    check_term(1'b1);

    // beq taken, bne not taken
    reset_start();
    do_instr(4'd4, 4'd0, 1'b1, 1'b0, 0, 0, term);
    do_instr(4'd5, 4'd0, 1'b1, 1'b0, 0, 0, term);
    check_ret("ret_after_branches");

    // lw with three stall cycles, sw with two
    do_instr(4'd2, 4'd0, 1'b0, 1'b0, 0, 3, term);
    do_instr(4'd3, 4'd0, 1'b0, 1'b0, 1, 2, term);
    check_ret("ret_after_mem");

    // Narrow counter reaches all-ones then wraps to zero
    while (ret_m[3:0] != 4'hF) do_instr(4'd6, 4'd0, 1'b0, 1'b0, 0, 0, term);
    check("w4_all_ones", retired4, 4'hF);
    do_instr(4'd6, 4'd0, 1'b0, 1'b0, 0, 0, term);
    check("w4_wrap", retired4, 4'h0);
    check_ret("ret_after_wrap");

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) opc = 4'($urandom_range(7, 15));
      else opc = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) fn = 4'($urandom_range(0, 15));
      else fn = 4'($urandom_range(1, 12));
      iz = 1'($urandom_range(0, 1));
      ov = ($urandom_range(0, 9) == 0);
      do_instr(opc, fn, iz, ov, $urandom_range(0, 1), $urandom_range(0, 3), term);
      if (term != 0) begin
        check_term(term == 1);
        reset_start();
      end
    end

    // Reset asserted mid-MEMACC clears everything without a clock edge
    reset_start();
    do_instr(4'd0, 4'd9, 1'b0, 1'b0, 0, 0, term);
    opcode = 4'd2; funct = 4'd0;
    step("m_fetch", with_op(A_ADD) | M_MR | M_IRW | M_PCW);
    step("m_decode", with_op(A_ADD) | M_SRC);
    step("m_memaddr", with_op(A_ADD) | M_SRC);
    mem_ready = 1'b0;
    #3;
    check("m_memacc", obs, M_MR);
    reset = 1'b1;
    #2;
    check("async_rst_outputs", obs, 15'h0);
    check("async_rst_retired", retired, 16'h0);
    check("async_rst_retired_w4", retired4, 4'h0);
    reset_start();
    do_instr(4'd7, 4'd0, 1'b0, 1'b0, 0, 0, term);
    check("halt_term", term, 2);
    check_term(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one parameter: RETIRE_W, default 16, width of the retired-instruction counter.
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: pulse that leaves IDLE.
REQ-005 The block SHALL have the port opcode, input, 4 bits: instruction register bits [15:12].
REQ-006 The block SHALL have the port funct, input, 4 bits: instruction register bits [3:0], the R-type ALU operation.
REQ-007 The block SHALL have the port isZero, input, 1 bit: ALU result-zero flag from ALUSystem.
REQ-008 The block SHALL have the port ovfl, input, 1 bit: ALU signed-overflow flag from ALUSystem.
REQ-009 The block SHALL have the port mem_ready, input, 1 bit: memory completes the current read or write this cycle.
REQ-010 The block SHALL have the port alu_op, output, 4 bits, with the encodings 0001 add, 0010 sub, 0011 land, 0100 lor, 0101 slt, 0110 and, 0111 or, 1000 nor, 1001 xor, 1010 sll, 1011 srl, 1100 sra.
REQ-011 The block SHALL have the port alu_src, output, 1 bit: 0 selects the B operand, 1 selects ALUSrc_b.
REQ-012 The block SHALL have the ports ir_write and pc_write, outputs, 1 bit each: load the instruction register, load the PC.
REQ-013 The block SHALL have the port pc_src, output, 2 bits: 00 ALU result R, 01 branch target br, 10 jump target.
REQ-014 The block SHALL have the ports mem_read and mem_write, outputs, 1 bit each: memory strobes.
REQ-015 The block SHALL have the ports reg_write and mem_to_reg, outputs, 1 bit each: register-file write enable, and write-data select (1 selects memory data).
REQ-016 The block SHALL have the ports trap and halted, outputs, 1 bit each: sticky status flags.
REQ-017 The block SHALL have the port retired, output, RETIRE_W bits: count of completed instructions.

Function
REQ-018 IDLE: the block SHALL drive all outputs to 0 and SHALL move to FETCH on the first edge where start=1.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 FETCH: mem_read=1, alu_op=add, alu_src=0; the state SHALL hold while mem_ready=0.
REQ-021 In the FETCH cycle with mem_ready=1: ir_write=1, pc_write=1, pc_src=00, and the next state is DECODE.
REQ-022 DECODE (1 cycle): alu_op=add, alu_src=1 to form the branch target.
REQ-023 DECODE dispatch: opcode 0 → EXEC_R, 1 (addi) → EXEC_I, 2 (lw) or 3 (sw) → MEMADDR, 4 (beq) or 5 (bne) → BRANCH, 6 (j) → JUMP, 7 → HALT, 8–F → TRAP.
REQ-024 EXEC_R: alu_op=funct, alu_src=0; funct 0000 or 1101–1111 SHALL go to TRAP; otherwise next state is WB.
REQ-025 EXEC_I: alu_op=add, alu_src=1; next state is WB.
REQ-026 WB: alu_op and alu_src held from EXEC; reg_write=1, except for add, sub or addi with ovfl=1, where reg_write=0 and the next state is TRAP; otherwise next state is FETCH.
REQ-027 MEMADDR: alu_op=add, alu_src=1; next state is MEMACC.
REQ-028 MEMACC: mem_read=1 (lw) or mem_write=1 (sw), held until mem_ready=1; lw then goes to WBMEM, sw then goes to FETCH.
REQ-029 WBMEM: reg_write=1, mem_to_reg=1; next state is FETCH.
REQ-030 BRANCH: alu_op=sub, alu_src=0; pc_write=1 and pc_src=01 in the same cycle iff (beq and isZero=1) or (bne and isZero=0); next state is FETCH.
REQ-031 JUMP: pc_write=1, pc_src=10; next state is FETCH.
REQ-032 HALT and TRAP SHALL be terminal until reset; they assert halted and trap respectively, with all strobes 0.
REQ-033 Outputs SHALL be Moore-decoded from state, except the BRANCH pc_write (depends on isZero) and the WB reg_write (depends on ovfl).
REQ-034 retired SHALL increment by 1 on the final cycle of WB, WBMEM, the completing sw MEMACC, BRANCH (taken or not) and JUMP, and SHALL wrap from all-ones to 0.
REQ-035 HALT and TRAP SHALL NOT increment retired.
REQ-036 With mem_ready=1 throughout, latency SHALL be: R-type/addi 4 cycles, lw 5, sw 4, branch 3, j 3.

Reset
REQ-037 While reset=1, and asynchronously on its assertion, the block SHALL force state to IDLE, every output to 0 and retired to 0, abandoning any in-flight memory access.
REQ-038 After reset deasserts, the block SHALL remain in IDLE until start=1.

Structure
REQ-039 A shared include alu_defs SHALL hold the alu_op encodings, the ISA opcode constants and the state encodings, so that ALUSystem and this block use one source.
REQ-040 retired SHALL be implemented as a sub-module retire_counter (enable, wrap, asynchronous clear).

Verification
REQ-041 Verification SHALL cover: reset, then start, with opcode=0, funct=0001, ovfl=0, mem_ready=1 → states FETCH, DECODE, EXEC_R, WB; reg_write=1 in cycle 4; retired=1.
REQ-042 Verification SHALL cover: opcode=1 with ovfl=1 during WB → reg_write stays 0, trap=1 thereafter, retired unchanged, start ignored.
REQ-043 Verification SHALL cover: opcode=4 with isZero=1 → pc_write=1, pc_src=01 in BRANCH; opcode=5 with isZero=1 → pc_write=0; retired increments in both cases.
REQ-044 Verification SHALL cover: opcode=2 with mem_ready low for 3 cycles in MEMACC → mem_read held for 4 cycles, then WBMEM with mem_to_reg=1.
REQ-045 Verification SHALL cover: reset asserted mid-MEMACC → all outputs 0 immediately, no clock edge needed; then opcode=7 → halted=1 and sticky.
REQ-046 Verification SHALL cover: retired preloaded to FFFF by running 65535 instructions, then one more instruction → retired=0000.
